uart_poll_sched: RTL and testbench

UART_POLL_SCHED -- requirements
Module: uart_poll_sched

---
 rtl/uart_poll_sched.sv | 186 ++++++++++++++++++
 tb/tb_uart_poll_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_poll_sched.sv
// Round-robin RS485 poll scheduler: sends a request on each channel in turn,
// collects a fixed-length response into a shared buffer and reports per-channel ok/err.
module uart_poll_sched #(
    parameter int NCH    = 5,
    parameter int NBYTES = 20,
    parameter int TO_CYC = 4000,
    parameter int GUARD  = 16
) (
    input  logic           clk80MHz,
    input  logic           rst,
    input  logic           start,
    input  logic           tx_done,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic [2:0]     sel,
    output logic           tx_start,
    output logic [NCH-1:0] UART_dTX,
    output logic [NCH-1:0] UART_dRX,
    output logic           buf_we,
    output logic [6:0]     buf_addr,
    output logic [7:0]     buf_data,
    output logic [NCH-1:0] ok,
    output logic [NCH-1:0] err,
    output logic           cycle_done,
    output logic           busy,
    output logic           overrun
);

    localparam int TW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
    localparam int GW = (GUARD < 2)  ? 1 : $clog2(GUARD + 1);
    localparam int CW = (NBYTES < 2) ? 1 : $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_GUARD,
        S_RX,
        S_NEXT
    } state_t;

    state_t         state_q;
    logic [2:0]     sel_q;
    logic [6:0]     base_q;
    logic [NCH-1:0] drv_q;
    logic [GW-1:0]  guard_q;
    logic [TW-1:0]  timer_q;
    logic [CW-1:0]  cnt_q;
    logic [NCH-1:0] workOk_q;
    logic [NCH-1:0] workErr_q;
    logic [NCH-1:0] ok_q;
    logic [NCH-1:0] err_q;
    logic           txStart_q;
    logic           bufWe_q;
    logic [6:0]     bufAddr_q;
    logic [7:0]     bufData_q;
    logic           cycleDone_q;
    logic           busy_q;
    logic           overrun_q;

    logic [NCH-1:0] selOneHot;
    logic [NCH-1:0] workOk_d;
    logic [NCH-1:0] workErr_d;
    logic           lastSel;
    logic           lastByte;
    logic           timeout;
    logic           rxFinish;

    // A byte arriving on the expiry clock wins over the timeout.
    always_comb begin
        selOneHot = NCH'(1) << sel_q;
        lastSel   = (sel_q == 3'(NCH - 1));
        lastByte  = rx_valid && (cnt_q == CW'(NBYTES - 1));
        timeout   = !rx_valid && (timer_q == '0);
        rxFinish  = lastByte || timeout;
        workOk_d  = workOk_q  | (lastByte ? selOneHot : '0);
        workErr_d = workErr_q | (timeout  ? selOneHot : '0);
    end

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            base_q      <= '0;
            drv_q       <= '0;
            guard_q     <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            workOk_q    <= '0;
            workErr_q   <= '0;
            ok_q        <= '0;
            err_q       <= '0;
            txStart_q   <= 1'b0;
            bufWe_q     <= 1'b0;
            bufAddr_q   <= '0;
            bufData_q   <= '0;
            cycleDone_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            txStart_q   <= 1'b0;
            bufWe_q     <= 1'b0;
            cycleDone_q <= 1'b0;
            // The final NEXT clock is the cycle_done clock; a start there is dropped silently.
            overrun_q   <= start && (state_q != S_IDLE) && !cycleDone_q;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q     <= '0;
                        base_q    <= '0;
                        workOk_q  <= '0;
                        workErr_q <= '0;
                        drv_q     <= NCH'(1);
                        txStart_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_TX;
                    end
                end
                S_TX: begin
                    if (tx_done) begin
                        guard_q <= GW'(GUARD);
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (guard_q <= GW'(1)) begin
                        drv_q   <= '0;
                        cnt_q   <= '0;
                        timer_q <= TW'(TO_CYC);
                        state_q <= S_RX;
                    end else begin
                        guard_q <= guard_q - 1'b1;
                    end
                end
                S_RX: begin
                    if (rx_valid) begin
                        bufWe_q   <= 1'b1;
                        bufAddr_q <= base_q + 7'(cnt_q);
                        bufData_q <= rx_data;
                        cnt_q     <= cnt_q + 1'b1;
                        timer_q   <= TW'(TO_CYC);
                    end else if (!timeout) begin
                        timer_q <= timer_q - 1'b1;
                    end
                    if (rxFinish) begin
                        workOk_q  <= workOk_d;
                        workErr_q <= workErr_d;
                        state_q   <= S_NEXT;
                        if (lastSel) begin
                            ok_q        <= workOk_d;
                            err_q       <= workErr_d;
                            cycleDone_q <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (!lastSel) begin
                        sel_q     <= sel_q + 3'd1;
                        base_q    <= base_q + 7'(NBYTES);
                        drv_q     <= selOneHot << 1;
                        txStart_q <= 1'b1;
                        state_q   <= S_TX;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel        = sel_q;
    assign tx_start   = txStart_q;
    assign UART_dTX   = drv_q;
    assign UART_dRX   = drv_q;
    assign buf_we     = bufWe_q;
    assign buf_addr   = bufAddr_q;
    assign buf_data   = bufData_q;
    assign ok         = ok_q;
    assign err        = err_q;
    assign cycle_done = cycleDone_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_poll_sched.sv
// Bench for uart_poll_sched: behavioural channel responders feed random responses,
// and each scenario task compares the DUT against expectations derived from the channel setup.
module tb_uart_poll_sched;

    localparam int NCH    = 5;
    localparam int NBYTES = 20;
    localparam int TO     = 400;
    localparam int GD     = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           tx_done;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic [2:0]     sel;
    logic           tx_start;
    logic [NCH-1:0] UART_dTX;
    logic [NCH-1:0] UART_dRX;
    logic           buf_we;
    logic [6:0]     buf_addr;
    logic [7:0]     buf_data;
    logic [NCH-1:0] ok;
    logic [NCH-1:0] err;
    logic           cycle_done;
    logic           busy;
    logic           overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int respBytes [NCH];
    int txCyc [NCH];
    int dropCyc [NCH];
    int lastWeCyc [NCH];
    bit txDoneFlag [NCH];
    int txSelQ [$];
    int expWrQ [$];
    int actWrQ [$];
    int cycleDoneCnt = 0;
    int overrunCnt = 0;
    int ohViol = 0;
    logic [NCH-1:0] prevDrv;

    uart_poll_sched #(.NCH(NCH), .NBYTES(NBYTES), .TO_CYC(TO), .GUARD(GD)) dut (
        .clk80MHz(clk), .rst(rst), .start(start), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_data(rx_data), .sel(sel), .tx_start(tx_start),
        .UART_dTX(UART_dTX), .UART_dRX(UART_dRX), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_data(buf_data), .ok(ok), .err(err),
        .cycle_done(cycle_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Observes the DUT every clock on the falling edge and logs events with cycle stamps.
    initial begin
        prevDrv = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if ($countones(UART_dTX) > 1 || $countones(UART_dRX) > 1) ohViol++;
            if (cycle_done) cycleDoneCnt++;
            if (rst) begin
                if (buf_we) begin
                    actWrQ.push_back(int'({buf_addr, buf_data}));
                    if (int'(buf_addr) < NCH * NBYTES) lastWeCyc[int'(buf_addr) / NBYTES] = cyc;
                end
                if (tx_start) begin
                    txSelQ.push_back(int'(sel));
                    if (int'(sel) < NCH) txCyc[sel] = cyc;
                end
                if (prevDrv != '0 && UART_dRX == '0 && int'(sel) < NCH) dropCyc[sel] = cyc;
                if (overrun) overrunCnt++;
            end
            prevDrv = UART_dRX;
        end
    end

    // Channel model: answers tx_start with tx_done, then sends respBytes[ch] bytes once listening.
    task automatic serveChannel(input int ch);
        int dly;
        int gap;
        dly = $urandom_range(1, 6);
        for (int i = 0; i < dly; i++) begin
            rx_valid = (i == 0);
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_done = 1'b1;
        txDoneFlag[ch] = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int w = 0; w < GD + 10 && UART_dRX != '0 && rst; w++) @(negedge clk);
        if (!rst) return;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int b = 0; b < respBytes[ch]; b++) begin
            gap = $urandom_range(0, 8);
            repeat (gap) @(negedge clk);
            if (!rst) return;
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            expWrQ.push_back(((ch * NBYTES + b) << 8) | int'(rx_data));
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && tx_start) serveChannel(int'(sel));
        end
    end

    function automatic logic [NCH-1:0] expOkBits();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (respBytes[c] >= NBYTES);
        return r;
    endfunction

    task automatic applyStimulus(input bit injectOverrun, input bit startOnDone, output bit done);
        bit injected;
        injected = 1'b0;
        done = 1'b0;
        txSelQ.delete();
        expWrQ.delete();
        actWrQ.delete();
        for (int c = 0; c < NCH; c++) begin
            txCyc[c] = -1;
            dropCyc[c] = -1;
            lastWeCyc[c] = -1;
            txDoneFlag[c] = 1'b0;
        end
        cycleDoneCnt = 0;
        overrunCnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (cycle_done) begin
                done = 1'b1;
                break;
            end
            if (injectOverrun && !injected && dropCyc[1] >= 0 && cyc >= dropCyc[1] + 2) begin
                start = 1'b1;
                injected = 1'b1;
            end
        end
        if (startOnDone) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (UART_dTX !== '0 || UART_dRX !== '0) begin failures++; $display("FAIL reset_drv got %b/%b want 0/0", UART_dTX, UART_dRX); end
        checks++; if (buf_we !== 1'b0 || buf_addr !== '0 || buf_data !== '0) begin failures++; $display("FAIL reset_buf got %b/%0d/%0d want 0/0/0", buf_we, buf_addr, buf_data); end
        checks++; if (ok !== '0 || err !== '0) begin failures++; $display("FAIL reset_okerr got %b/%b want 0/0", ok, err); end
        checks++; if (cycle_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_flags got %b%b%b want 000", cycle_done, busy, overrun); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_cycle();
        bit done;
        for (int c = 0; c < NCH; c++) respBytes[c] = NBYTES;
        applyStimulus(1'b0, 1'b0, done);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got timeout want cycle_done"); end
        checks++; if (ok !== 5'b11111) begin failures++; $display("FAIL full_ok got %b want 11111", ok); end
        checks++; if (err !== 5'b00000) begin failures++; $display("FAIL full_err got %b want 00000", err); end
        checks++; if (cycleDoneCnt !== 1) begin failures++; $display("FAIL full_cycle_done got %0d want 1", cycleDoneCnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy got %b want 0", busy); end
        checks++; if (txSelQ.size() !== NCH) begin failures++; $display("FAIL full_tx_count got %0d want %0d", txSelQ.size(), NCH); end
        for (int i = 0; i < txSelQ.size() && i < NCH; i++) begin
            checks++; if (txSelQ[i] !== i) begin failures++; $display("FAIL full_tx_sel[%0d] got %0d want %0d", i, txSelQ[i], i); end
        end
        checks++; if (actWrQ.size() !== NCH * NBYTES) begin failures++; $display("FAIL full_wr_count got %0d want %0d", actWrQ.size(), NCH * NBYTES); end
        for (int i = 0; i < actWrQ.size() && i < expWrQ.size(); i++) begin
            checks++; if (actWrQ[i] !== expWrQ[i]) begin failures++; $display("FAIL full_wr[%0d] got %h want %h", i, actWrQ[i], expWrQ[i]); end
        end
    endtask

    task automatic test_silent_ch2();
        bit done;
        int inRange;
        int d;
        for (int c = 0; c < NCH; c++) respBytes[c] = (c == 2) ? 0 : NBYTES;
        applyStimulus(1'b0, 1'b0, done);
        inRange = 0;
        foreach (actWrQ[i]) if ((actWrQ[i] >> 8) >= 40 && (actWrQ[i] >> 8) <= 59) inRange++;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL silent_done got timeout want cycle_done"); end
        checks++; if (ok !== 5'b11011) begin failures++; $display("FAIL silent_ok got %b want 11011", ok); end
        checks++; if (err !== 5'b00100) begin failures++; $display("FAIL silent_err got %b want 00100", err); end
        checks++; if (inRange !== 0) begin failures++; $display("FAIL silent_no_write got %0d writes want 0", inRange); end
        d = txCyc[3] - dropCyc[2];
        checks++; if (d < TO + 1 || d > TO + 3) begin failures++; $display("FAIL silent_timing got %0d want %0d..%0d", d, TO + 1, TO + 3); end
        checks++; if (actWrQ.size() !== expWrQ.size()) begin failures++; $display("FAIL silent_wr_count got %0d want %0d", actWrQ.size(), expWrQ.size()); end
        for (int i = 0; i < actWrQ.size() && i < expWrQ.size(); i++) begin
            checks++; if (actWrQ[i] !== expWrQ[i]) begin failures++; $display("FAIL silent_wr[%0d] got %h want %h", i, actWrQ[i], expWrQ[i]); end
        end
    endtask

    task automatic test_partial_ch0();
        bit done;
        int d;
        for (int c = 0; c < NCH; c++) respBytes[c] = (c == 0) ? 7 : NBYTES;
        applyStimulus(1'b0, 1'b0, done);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL partial_done got timeout want cycle_done"); end
        checks++; if (err !== 5'b00001 || ok !== 5'b11110) begin failures++; $display("FAIL partial_okerr got %b/%b want 11110/00001", ok, err); end
        d = txCyc[1] - lastWeCyc[0];
        checks++; if (d < TO + 1 || d > TO + 3) begin failures++; $display("FAIL partial_timing got %0d want %0d..%0d", d, TO + 1, TO + 3); end
        checks++; if (actWrQ.size() !== 7 + (NCH - 1) * NBYTES) begin failures++; $display("FAIL partial_wr_count got %0d want %0d", actWrQ.size(), 7 + (NCH - 1) * NBYTES); end
        for (int i = 0; i < actWrQ.size() && i < expWrQ.size(); i++) begin
            checks++; if (actWrQ[i] !== expWrQ[i]) begin failures++; $display("FAIL partial_wr[%0d] got %h want %h", i, actWrQ[i], expWrQ[i]); end
        end
    endtask

    task automatic test_overrun();
        bit done;
        for (int c = 0; c < NCH; c++) respBytes[c] = NBYTES;
        applyStimulus(1'b1, 1'b0, done);
        checks++; if (overrunCnt !== 1) begin failures++; $display("FAIL overrun_pulse got %0d clocks want 1", overrunCnt); end
        checks++; if (ok !== 5'b11111 || err !== '0) begin failures++; $display("FAIL overrun_okerr got %b/%b want 11111/00000", ok, err); end
        checks++; if (txSelQ.size() !== NCH || actWrQ.size() !== NCH * NBYTES) begin failures++; $display("FAIL overrun_cycle got %0d tx/%0d wr want %0d/%0d", txSelQ.size(), actWrQ.size(), NCH, NCH * NBYTES); end
    endtask

    task automatic test_start_on_done();
        bit done;
        for (int c = 0; c < NCH; c++) respBytes[c] = NBYTES;
        applyStimulus(1'b0, 1'b1, done);
        checks++; if (overrunCnt !== 0) begin failures++; $display("FAIL done_start_overrun got %0d want 0", overrunCnt); end
        checks++; if (txSelQ.size() !== NCH) begin failures++; $display("FAIL done_start_tx got %0d want %0d", txSelQ.size(), NCH); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_start_busy got %b want 0", busy); end
    endtask

    task automatic test_stray_idle();
        actWrQ.delete();
        txSelQ.delete();
        rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        rx_valid = 1'b0; tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (actWrQ.size() !== 0) begin failures++; $display("FAIL idle_stray_wr got %0d want 0", actWrQ.size()); end
        checks++; if (busy !== 1'b0 || txSelQ.size() !== 0) begin failures++; $display("FAIL idle_stray_state got busy=%b tx=%0d want 0/0", busy, txSelQ.size()); end
    endtask

    task automatic test_random();
        bit done;
        int r;
        int refCyc;
        int d;
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < NCH; c++) begin
                r = $urandom_range(0, 3);
                respBytes[c] = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, NBYTES - 1) : NBYTES;
            end
            applyStimulus(1'b0, 1'b0, done);
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL rand%0d_done got timeout want cycle_done", it); end
            checks++; if (ok !== expOkBits()) begin failures++; $display("FAIL rand%0d_ok got %b want %b", it, ok, expOkBits()); end
            checks++; if (err !== ~expOkBits()) begin failures++; $display("FAIL rand%0d_err got %b want %b", it, err, ~expOkBits()); end
            for (int c = 0; c < NCH - 1; c++) begin
                if (respBytes[c] < NBYTES) begin
                    refCyc = (respBytes[c] > 0) ? lastWeCyc[c] : dropCyc[c];
                    d = txCyc[c + 1] - refCyc;
                    checks++; if (d < TO + 1 || d > TO + 3) begin failures++; $display("FAIL rand%0d_timing ch%0d got %0d want %0d..%0d", it, c, d, TO + 1, TO + 3); end
                end
            end
            checks++; if (actWrQ.size() !== expWrQ.size()) begin failures++; $display("FAIL rand%0d_wr_count got %0d want %0d", it, actWrQ.size(), expWrQ.size()); end
            for (int i = 0; i < actWrQ.size() && i < expWrQ.size(); i++) begin
                checks++; if (actWrQ[i] !== expWrQ[i]) begin failures++; $display("FAIL rand%0d_wr[%0d] got %h want %h", it, i, actWrQ[i], expWrQ[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            respBytes[c] = (c == 3) ? 0 : NBYTES;
            txDoneFlag[c] = 1'b0;
        end
        txSelQ.delete();
        cycleDoneCnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (txDoneFlag[3]) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (!seen || UART_dTX !== 5'b01000 || sel !== 3'd3) begin failures++; $display("FAIL mid_guard got seen=%b dTX=%b sel=%0d want 1/01000/3", seen, UART_dTX, sel); end
        #1 rst = 1'b0;
        #1;
        checks++; if (UART_dTX !== '0 || UART_dRX !== '0) begin failures++; $display("FAIL mid_rst_drv got %b/%b want 0/0", UART_dTX, UART_dRX); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (cycleDoneCnt !== 0) begin failures++; $display("FAIL mid_cycle_done got %0d want 0", cycleDoneCnt); end
        checks++; if (ok !== '0 || err !== '0) begin failures++; $display("FAIL mid_okerr got %b/%b want 0/0", ok, err); end
        checks++; if (busy !== 1'b0 || txSelQ.size() !== 4) begin failures++; $display("FAIL mid_idle got busy=%b tx=%0d want 0/4", busy, txSelQ.size()); end
    endtask

    task automatic checkOutput();
        checks++; if (ohViol !== 0) begin failures++; $display("FAIL onehot_drv got %0d violations want 0", ohViol); end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_silent_ch2();
        test_partial_ch0();
        test_overrun();
        test_start_on_done();
        test_stray_idle();
        test_random();
        test_reset_mid();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
